// File: rtl/posit8_pkg.sv
// posit8_pkg: shared types and constants for the posit<8,0> (es=0) datapath.
//   POSIT_W, MAX_K, SIG_W, NAR : format constants
//   posit8_dec_t               : decoded operand {sign, k, sig (1.ffffff), zero, nar}
//   regime_run()               : length of the leading run of identical bits
package posit8_pkg;

   localparam int         POSIT_W = 8;
   localparam int         MAX_K   = 6;
   localparam int         SIG_W   = 7;
   localparam logic [7:0] NAR     = 8'h80;

   // k is a two's-complement value in -MAX_K..MAX_K
   typedef struct packed {
      logic       sign;
      logic [5:0] k;
      logic [6:0] sig;
      logic       zero;
      logic       nar;
   } posit8_dec_t;

   // Counts how many bits, starting at bits[6], equal bits[6] (1..7).
   function automatic logic [3:0] regime_run(input logic [6:0] bits);
      logic [3:0] n;
      logic       done;
      n    = 4'd0;
      done = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         if (!done && (bits[i] == bits[6])) begin
            n = n + 4'd1;
         end else begin
            done = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/posit8_to_fixed_stream_posit_fx_shifter.sv
// posit_fx_shifter: combinational shift / round / saturate / negate of a decoded posit.
//   dec     : in       decoded posit
//   fx      : out FX_W signed fixed-point result, LSB weight 2^-FX_FRAC
//   nar     : out 1    operand was NaR
//   sat     : out 1    magnitude clipped to the output range
//   inexact : out 1    nonzero bits were discarded (or value clipped)
// Build option: POSIT_FX_ROUND_EN selects round-to-nearest-even on right shifts;
// otherwise right shifts truncate the magnitude.
module posit_fx_shifter
   import posit8_pkg::*;
#(
   parameter int FX_W    = 16,
   parameter int FX_FRAC = 8
) (
   input  posit8_dec_t     dec,
   output logic [FX_W-1:0] fx,
   output logic            nar,
   output logic            sat,
   output logic            inexact
);

   // Deepest right shift is k=-6 with FX_FRAC=0: 12 bits fall below the LSB.
   localparam int GUARD_W = 2 * MAX_K;
   localparam int EXT_W   = 64;

   logic [EXT_W-1:0] ext_s;
   logic [EXT_W-1:0] mag_s;
   logic [EXT_W-1:0] lim_s;
   logic             sticky_s;
   logic             round_up_s;
   int               sh_s;

   // Place sig with GUARD_W fraction bits so every shift becomes a left shift
   always_comb begin
      sh_s     = int'($signed(dec.k)) + FX_FRAC + GUARD_W - (SIG_W - 1);
      ext_s    = {{(EXT_W-SIG_W){1'b0}}, dec.sig} << sh_s;
      sticky_s = |ext_s[GUARD_W-1:0];
`ifdef POSIT_FX_ROUND_EN
      // guard & (rest | lsb): round to nearest, ties to even
      round_up_s = ext_s[GUARD_W-1] & ((|ext_s[GUARD_W-2:0]) | ext_s[GUARD_W]);
`else
      round_up_s = 1'b0;
`endif
      mag_s = (ext_s >> GUARD_W) + {{(EXT_W-1){1'b0}}, round_up_s};
      lim_s = {{(EXT_W-1){1'b0}}, 1'b1} << (FX_W - 1);
   end

   // Special values, saturation, then sign applied to the rounded magnitude
   always_comb begin
      fx      = '0;
      nar     = 1'b0;
      sat     = 1'b0;
      inexact = 1'b0;
      if (dec.nar) begin
         fx  = lim_s[FX_W-1:0];
         nar = 1'b1;
      end else if (dec.zero) begin
         fx = '0;
      end else if (!dec.sign && (mag_s >= lim_s)) begin
         fx      = lim_s[FX_W-1:0] - {{(FX_W-1){1'b0}}, 1'b1};
         sat     = 1'b1;
         inexact = 1'b1;
      end else if (dec.sign && (mag_s > lim_s)) begin
         fx      = lim_s[FX_W-1:0];
         sat     = 1'b1;
         inexact = 1'b1;
      end else begin
         // -2^(FX_W-1) wraps to itself, which is the correct encoding
         fx      = dec.sign ? ({FX_W{1'b0}} - mag_s[FX_W-1:0]) : mag_s[FX_W-1:0];
         inexact = sticky_s;
      end
   end

endmodule

// File: rtl/posit_decoder_8bit.sv
// posit_decoder_8bit: combinational posit<8,0> field decoder.
//   posit : in  8  raw posit operand
//   dec   : out    decoded fields (sign, k, significand 1.ffffff, zero, nar)
// Negative operands are decoded from their two's-complement magnitude.
module posit_decoder_8bit
   import posit8_pkg::*;
(
   input  logic [POSIT_W-1:0] posit,
   output posit8_dec_t        dec
);

   logic [6:0] mag_s;
   logic [3:0] run_s;
   logic [5:0] frac_s;
   logic       zero_s;
   logic       nar_s;

   // Regime run length, then the fraction bits left after regime and terminator
   always_comb begin
      mag_s  = posit[7] ? (7'd0 - posit[6:0]) : posit[6:0];
      run_s  = regime_run(mag_s);
      // bits below the terminator, left-aligned (equivalent to mag << (run+1), top 6 bits)
      frac_s = 6'(mag_s[5:0] << run_s);
      zero_s = (posit == 8'h00);
      nar_s  = (posit == NAR);
   end

   // Assemble the decoded struct; special values carry neutral fields
   always_comb begin
      dec      = '0;
      dec.zero = zero_s;
      dec.nar  = nar_s;
      if (!zero_s && !nar_s) begin
         dec.sign = posit[7];
         dec.k    = mag_s[6] ? ({2'b00, run_s} - 6'd1) : (6'd0 - {2'b00, run_s});
         dec.sig  = {1'b1, frac_s};
      end else begin
         dec.sign = 1'b0;
         dec.k    = 6'd0;
         dec.sig  = 7'd0;
      end
   end

endmodule

// File: rtl/posit8_to_fixed_stream.sv
// posit8_to_fixed_stream: streaming posit<8,0> -> signed fixed-point converter.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake, in_posit is the operand
//   out_valid/out_ready    : output handshake
//   out_fx                 : FX_W-bit result, LSB weight 2^-FX_FRAC
//   out_nar/out_sat/out_inexact : NaR input, clipped, discarded nonzero bits
// Two stages: S1 holds the decoded operand, S2 holds the outputs.
// Build option: POSIT_FX_ROUND_EN (round to nearest even instead of truncation).
module posit8_to_fixed_stream
   import posit8_pkg::*;
#(
   parameter int FX_W    = 16,
   parameter int FX_FRAC = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [POSIT_W-1:0] in_posit,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FX_W-1:0]    out_fx,
   output logic               out_nar,
   output logic               out_sat,
   output logic               out_inexact
);

   posit8_dec_t     dec_s;
   posit8_dec_t     s1_dec_r;
   logic            s1_valid_r;
   logic            s1_adv_s;
   logic            s2_adv_s;
   logic [FX_W-1:0] fx_s;
   logic            nar_s;
   logic            sat_s;
   logic            inexact_s;

   posit_decoder_8bit u_dec (
      .posit (in_posit),
      .dec   (dec_s)
   );

   posit_fx_shifter #(
      .FX_W    (FX_W),
      .FX_FRAC (FX_FRAC)
   ) u_shift (
      .dec     (s1_dec_r),
      .fx      (fx_s),
      .nar     (nar_s),
      .sat     (sat_s),
      .inexact (inexact_s)
   );

   // A stage may load when empty or when the stage after it is draining
   always_comb begin
      s2_adv_s = ~out_valid | out_ready;
      s1_adv_s = ~s1_valid_r | s2_adv_s;
      in_ready = s1_adv_s;
   end

   // S1: decoded operand register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_dec_r   <= '0;
      end else if (s1_adv_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_dec_r <= dec_s;
         end
      end
   end

   // S2: output register, held while out_valid & ~out_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_fx      <= '0;
         out_nar     <= 1'b0;
         out_sat     <= 1'b0;
         out_inexact <= 1'b0;
      end else if (s2_adv_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_fx      <= fx_s;
            out_nar     <= nar_s;
            out_sat     <= sat_s;
            out_inexact <= inexact_s;
         end
      end
   end

endmodule

// File: tb/tb_posit8_to_fixed_stream.sv
// tb_posit8_to_fixed_stream: scoreboard bench for posit8_to_fixed_stream.
// Instance a: default params; b: FX_W=12, FX_FRAC=8; c: FX_W=16, FX_FRAC=4.
// Honors POSIT_FX_ROUND_EN for the rounding expectations.
module tb_posit8_to_fixed_stream;

   typedef struct packed {
      logic [18:0] v;     // {nar, sat, inexact, fx[15:0]}
      logic [31:0] cyc;   // cycle of acceptance
      logic        lat;   // check the 2-cycle latency
   } exp_t;

`ifdef POSIT_FX_ROUND_EN
   localparam logic [15:0] C43 = 16'h0012;
   localparam logic [15:0] CBD = 16'hFFEE;
`else
   localparam logic [15:0] C43 = 16'h0011;
   localparam logic [15:0] CBD = 16'hFFEF;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_posit;
   logic        in_valid_s  [3];
   logic        in_ready_s  [3];
   logic        out_valid_s [3];
   logic        out_ready_s [3];
   logic        nar_s [3];
   logic        sat_s [3];
   logic        inx_s [3];
   logic [15:0] fx_a;
   logic [11:0] fx_b;
   logic [15:0] fx_c;
   logic [31:0] cyc = 32'd0;
   int          checks = 0;
   int          failures = 0;
   int          out_cnt [3] = '{0, 0, 0};
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q2[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   posit8_to_fixed_stream dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .in_posit(in_posit), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
      .out_fx(fx_a), .out_nar(nar_s[0]), .out_sat(sat_s[0]), .out_inexact(inx_s[0]));

   posit8_to_fixed_stream #(.FX_W(12), .FX_FRAC(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .in_posit(in_posit), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
      .out_fx(fx_b), .out_nar(nar_s[1]), .out_sat(sat_s[1]), .out_inexact(inx_s[1]));

   posit8_to_fixed_stream #(.FX_W(16), .FX_FRAC(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .in_posit(in_posit), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
      .out_fx(fx_c), .out_nar(nar_s[2]), .out_sat(sat_s[2]), .out_inexact(inx_s[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] fx, input logic nar, input logic sat,
                               input logic inx, input logic lat);
      exp_t e;
      e.v   = {nar, sat, inx, fx};
      e.cyc = 32'd0;
      e.lat = lat;
      return e;
   endfunction

   function automatic int qsize(input int sel);
      if (sel == 0) return q0.size();
      else if (sel == 1) return q1.size();
      else return q2.size();
   endfunction

   task automatic push(input int sel, input exp_t e);
      case (sel)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Pop and compare one output transfer of instance sel
   task automatic mon(input int sel, input logic [18:0] got);
      exp_t e;
      int   sz;
      sz = qsize(sel);
      check($sformatf("sb_nonempty_%0d", sel), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
         case (sel)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check($sformatf("sb_out_%0d", sel), {13'd0, got}, {13'd0, e.v});
         if (e.lat) check($sformatf("sb_latency_%0d", sel), cyc, e.cyc + 32'd2);
      end
      out_cnt[sel]++;
   endtask

   always @(negedge clk)
      if (rst_n && out_valid_s[0] && out_ready_s[0]) mon(0, {nar_s[0], sat_s[0], inx_s[0], fx_a});
   always @(negedge clk)
      if (rst_n && out_valid_s[1] && out_ready_s[1]) mon(1, {nar_s[1], sat_s[1], inx_s[1], 4'd0, fx_b});
   always @(negedge clk)
      if (rst_n && out_valid_s[2] && out_ready_s[2]) mon(2, {nar_s[2], sat_s[2], inx_s[2], fx_c});

   // Present p on instance sel until accepted (bounded), recording the expectation
   task automatic send(input int sel, input logic [7:0] p, input exp_t e);
      logic done;
      done = 1'b0;
      in_posit = p;
      in_valid_s[sel] = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (in_ready_s[sel]) begin
            e.cyc = cyc;
            push(sel, e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid_s[sel] = 1'b0;
      check($sformatf("send_accept_%0d_%h", sel, p), {31'd0, done}, 32'd1);
   endtask

   task automatic drain(input int sel);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (qsize(sel) == 0) break;
      end
      @(posedge clk);
      #1;
      check($sformatf("drain_%0d", sel), 32'(qsize(sel)), 32'd0);
   endtask

   task automatic reset_state(input string tag);
      check({tag, "_out_valid"}, {31'd0, out_valid_s[0]}, 32'd0);
      check({tag, "_outputs"}, {13'd0, nar_s[0], sat_s[0], inx_s[0], fx_a}, 32'd0);
      check({tag, "_in_ready"}, {31'd0, in_ready_s[0]}, 32'd1);
   endtask

   logic [7:0] st_p [4];
   exp_t       st_e [4];
   int         idx;
   int         cnt_before;

   initial begin
      rst_n    = 1'b0;
      in_posit = 8'h00;
      for (int i = 0; i < 3; i++) begin
         in_valid_s[i]  = 1'b0;
         out_ready_s[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      reset_state("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back stream with latency checks
      send(0, 8'h40, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'hC0, mk(16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h50, mk(16'h0180, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h60, mk(16'h0200, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h7F, mk(16'h4000, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h01, mk(16'h0004, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h00, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h80, mk(16'h8000, 1'b1, 1'b0, 1'b0, 1'b1));
      send(0, 8'hFF, mk(16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h81, mk(16'hC000, 1'b0, 1'b0, 1'b0, 1'b1));
      send(0, 8'h02, mk(16'h0008, 1'b0, 1'b0, 1'b0, 1'b1));
      drain(0);

      // narrow output: saturation
      send(1, 8'h7F, mk(16'h07FF, 1'b0, 1'b1, 1'b1, 1'b1));
      send(1, 8'h81, mk(16'h0800, 1'b0, 1'b1, 1'b1, 1'b1));
      send(1, 8'h40, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b1));
      drain(1);

      // FX_FRAC=4: right shifts with discarded bits
      send(2, 8'h43, mk(C43, 1'b0, 1'b0, 1'b1, 1'b1));
      send(2, 8'hBD, mk(CBD, 1'b0, 1'b0, 1'b1, 1'b1));
      send(2, 8'h40, mk(16'h0010, 1'b0, 1'b0, 1'b0, 1'b1));
      drain(2);

      // stall: out_ready low for 5 cycles with in_valid held high
      st_p = '{8'h50, 8'h60, 8'h7F, 8'h01};
      st_e[0] = mk(16'h0180, 1'b0, 1'b0, 1'b0, 1'b0);
      st_e[1] = mk(16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
      st_e[2] = mk(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
      st_e[3] = mk(16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
      idx = 0;
      out_ready_s[0] = 1'b0;
      in_valid_s[0]  = 1'b1;
      in_posit       = st_p[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            check("stall_valid", {31'd0, out_valid_s[0]}, 32'd1);
            check("stall_hold_fx", {16'd0, fx_a}, 32'h0000_0180);
         end
         if (in_ready_s[0] && idx < 2) begin
            push(0, st_e[idx]);
            idx++;
         end
         @(posedge clk);
         #1;
         in_posit = st_p[idx];
      end
      check("stall_accepts", 32'(idx), 32'd2);
      check("stall_in_ready_low", {31'd0, in_ready_s[0]}, 32'd0);
      in_valid_s[0]  = 1'b0;
      out_ready_s[0] = 1'b1;
      send(0, st_p[2], st_e[2]);
      send(0, st_p[3], st_e[3]);
      drain(0);

      // asynchronous reset with both stages full
      out_ready_s[0] = 1'b0;
      send(0, 8'h40, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0));
      send(0, 8'h7F, mk(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0));
      check("full_before_reset", {31'd0, out_valid_s[0]}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      reset_state("midreset");
      q0.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready_s[0] = 1'b1;
      cnt_before = out_cnt[0];
      send(0, 8'h40, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b1));
      drain(0);
      repeat (4) @(posedge clk);
      #1;
      check("post_reset_one_output", 32'(out_cnt[0] - cnt_before), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
